// File: rtl/memory_pkg.sv
// Shared types and boot image for the heap memory controller.
// Boot image words are 8 bits; consumers resize them to their data width.
package memory_pkg;

    typedef enum logic [0:0] {
        BOOT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int BOOT_IMAGE_LEN = 4;
    localparam int BOOT_IDX_W     = $clog2(BOOT_IMAGE_LEN);

    // Element [i] is boot word i.
    localparam logic [BOOT_IMAGE_LEN-1:0][7:0] BOOT_IMAGE = {8'h01, 8'h10, 8'h2A, 8'h00};

    function automatic logic [7:0] boot_word(input logic [31:0] index);
        logic [7:0] w;
        w = 8'h00;
        if (index < 32'(BOOT_IMAGE_LEN))
            w = BOOT_IMAGE[index[BOOT_IDX_W-1:0]];
        return w;
    endfunction

endpackage

// File: rtl/memory_controller_boot_rom.sv
// Combinational boot image lookup: word index -> DATA_WIDTH word.
// Image entries are zero-extended or truncated to DATA_WIDTH.
module boot_rom
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] i_index,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [7:0] w_raw;

    always_comb begin
        w_raw  = boot_word(32'(i_index));
        o_word = DATA_WIDTH'(w_raw);
    end

endmodule

// File: rtl/memory_controller.sv
// Heap RAM with a boot sequencer that copies the boot image into every word after reset.
// Define WRITE_FORWARD_EN for write-first reads; default is read-first.
module memory_controller
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_boot_done,
    input  logic                  i_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic [DATA_WIDTH-1:0] o_read_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_boot_done;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] r_ram [DEPTH];

    logic [DATA_WIDTH-1:0] w_boot_word;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    boot_rom #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_boot_rom (
        .i_index(r_cnt),
        .o_word (w_boot_word)
    );

    // The boot copy owns the write port until READY; user strobes are dropped.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = i_addr;
        w_ram_wdata = i_write_data;
        if (r_state == BOOT) begin
            w_ram_we    = !i_rst;
            w_ram_addr  = r_cnt;
            w_ram_wdata = w_boot_word;
        end else begin
            w_ram_we = !i_rst && i_write_enable;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_ram_we)
            r_ram[w_ram_addr] <= w_ram_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= BOOT;
            r_cnt       <= '0;
            r_boot_done <= 1'b0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_read_data <= '0;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state     <= READY;
                        r_boot_done <= 1'b1;
                    end
                end
                READY: begin
`ifdef WRITE_FORWARD_EN
                    if (i_write_enable)
                        r_read_data <= i_write_data;
                    else
                        r_read_data <= r_ram[i_addr];
`else
                    r_read_data <= r_ram[i_addr];
`endif
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    assign o_boot_done = r_boot_done;
    assign o_read_data = r_read_data;

endmodule

// File: tb/tb_memory_controller.sv
// Directed self-checking bench for memory_controller (default 6-bit address, 8-bit data).
// Honours WRITE_FORWARD_EN for the same-edge read/write expectation.
module tb_memory_controller;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          boot_done;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    int checks = 0;
    int errors = 0;

    memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_boot_done   (boot_done),
        .i_write_enable(we),
        .i_addr        (addr),
        .i_write_data  (wdata),
        .o_read_data   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts edges from the current point until boot_done; checks read_data stays 0 meanwhile.
    task automatic wait_boot(input string name, output int edges);
        bit rd_bad;
        rd_bad = 0;
        edges  = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            edges++;
            if (rdata !== 8'h00) rd_bad = 1;
            if (boot_done === 1'b1) break;
        end
        checks++;
        if (boot_done !== 1'b1) begin
            errors++;
            $display("FAIL %s boot_timeout: boot_done=%b after %0d edges, required 1", name, boot_done, edges);
        end
        checks++;
        if (rd_bad) begin
            errors++;
            $display("FAIL %s read_during_boot: read_data nonzero during boot, required 00", name);
        end
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
        addr = a;
        we   = 1'b0;
        @(posedge clk); #1;
        d = rdata;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk); #1;
        we    = 1'b0;
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int edges;
        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        #3;
        checks++;
        if (boot_done !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: boot_done=%b read_data=%h, required 0/00", boot_done, rdata);
        end
        repeat (2) @(posedge clk);
        release_rst();
        wait_boot("reset", edges);
        checks++;
        if (edges !== 64) begin
            errors++;
            $display("FAIL boot_latency: %0d edges, required 64", edges);
        end
    endtask

    task automatic test_image_reads;
        logic [DW-1:0] d;
        logic [AW-1:0] a_tab [5] = '{6'h01, 6'h02, 6'h03, 6'h00, 6'h3F};
        logic [DW-1:0] e_tab [5] = '{8'h2A, 8'h10, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            read_word(a_tab[i], d);
            checks++;
            if (d !== e_tab[i]) begin
                errors++;
                $display("FAIL image_read addr=%h: got %h, required %h", a_tab[i], d, e_tab[i]);
            end
        end
        // Holding the address must hold the data.
        read_word(6'h01, d);
        @(posedge clk); #1;
        checks++;
        if (rdata !== 8'h2A) begin
            errors++;
            $display("FAIL read_stable: got %h, required 2a", rdata);
        end
    endtask

    task automatic test_write_during_boot;
        int edges;
        logic [DW-1:0] d;
        rst = 1'b1;
        #2;
        release_rst();
        addr = 6'h05; wdata = 8'hFF; we = 1'b1;
        wait_boot("boot_write", edges);
        we = 1'b0;
        checks++;
        if (edges !== 64) begin
            errors++;
            $display("FAIL boot_write_latency: %0d edges, required 64", edges);
        end
        read_word(6'h05, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL boot_write_ignored: addr 05 got %h, required 00", d);
        end
    endtask

    task automatic test_write_read;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_same;
`ifdef WRITE_FORWARD_EN
        exp_same = 8'hA5;
`else
        exp_same = 8'h5A;
`endif
        write_word(6'h07, 8'h5A);
        read_word(6'h07, d);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("FAIL write_read: addr 07 got %h, required 5a", d);
        end
        write_word(6'h07, 8'hA5);
        checks++;
        if (rdata !== exp_same) begin
            errors++;
            $display("FAIL read_during_write: got %h, required %h", rdata, exp_same);
        end
        read_word(6'h07, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL write_read2: addr 07 got %h, required a5", d);
        end
    endtask

    task automatic test_reset_ready;
        int edges;
        logic [DW-1:0] d;
        write_word(6'h01, 8'h77);
        read_word(6'h01, d);
        checks++;
        if (d !== 8'h77) begin
            errors++;
            $display("FAIL ready_write: addr 01 got %h, required 77", d);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (boot_done !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_ready: boot_done=%b read_data=%h, required 0/00", boot_done, rdata);
        end
        release_rst();
        wait_boot("reset_ready", edges);
        checks++;
        if (edges !== 64) begin
            errors++;
            $display("FAIL reboot_latency: %0d edges, required 64", edges);
        end
        read_word(6'h01, d);
        checks++;
        if (d !== 8'h2A) begin
            errors++;
            $display("FAIL reboot_overwrite: addr 01 got %h, required 2a", d);
        end
    endtask

    task automatic test_reset_midboot;
        int edges;
        logic [DW-1:0] d;
        bit early;
        logic [DW-1:0] img [4] = '{8'h00, 8'h2A, 8'h10, 8'h01};
        rst = 1'b1;
        #2;
        release_rst();
        early = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (boot_done !== 1'b0) early = 1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (early || boot_done !== 1'b0) begin
            errors++;
            $display("FAIL midboot_done: boot_done went high early or after rst, required 0");
        end
        repeat (2) @(posedge clk);
        release_rst();
        wait_boot("midboot", edges);
        checks++;
        if (edges !== 64) begin
            errors++;
            $display("FAIL midboot_latency: %0d edges, required 64", edges);
        end
        for (int i = 0; i < 4; i++) begin
            read_word(AW'(i), d);
            checks++;
            if (d !== img[i]) begin
                errors++;
                $display("FAIL midboot_image addr=%0d: got %h, required %h", i, d, img[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_image_reads();
        test_write_during_boot();
        test_write_read();
        test_reset_ready();
        test_reset_midboot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
